// File: rtl/audio_mixer_pkg.sv
// rtl/audio_mixer_pkg.sv - register map, reset defaults, state encoding and step helper for the mixer fader
//
// Shared by audio_mixer_fader and fader_tick_gen. Holds the mixer register
// address map, the power-on contents of each mixer register, the fader state
// encoding and the saturating ramp-step function.
package audio_mixer_pkg;

   localparam logic [3:0] REG_VOL_A = 4'd0;
   localparam logic [3:0] REG_VOL_B = 4'd1;
   localparam logic [3:0] REG_VOL_C = 4'd2;
   localparam logic [3:0] REG_VOL_D = 4'd3;
   localparam logic [3:0] REG_VOL_E = 4'd4;
   localparam logic [3:0] REG_VOL_F = 4'd5;
   localparam logic [3:0] REG_MVOL  = 4'd6;
   localparam logic [3:0] REG_INV   = 4'd7;
   localparam logic [3:0] REG_BASS  = 4'd8;
   localparam logic [3:0] REG_TREB  = 4'd9;

   localparam int NUM_DEFAULT_REGS = 10;

   localparam logic [7:0] REG_DEFAULTS [NUM_DEFAULT_REGS] = '{
      8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd128, 8'd0, 8'd25, 8'd128
   };

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_WAIT = 3'd1,
      ST_RD_CAP  = 3'd2,
      ST_WAIT    = 3'd3,
      ST_STEP    = 3'd4,
      ST_DONE    = 3'd5
   } fader_state_t;

   // Reset value of a mixer register; addresses outside the map read as 0.
   function automatic logic [7:0] reg_default(input logic [3:0] idx);
      case (idx)
         4'd0:    reg_default = REG_DEFAULTS[0];
         4'd1:    reg_default = REG_DEFAULTS[1];
         4'd2:    reg_default = REG_DEFAULTS[2];
         4'd3:    reg_default = REG_DEFAULTS[3];
         4'd4:    reg_default = REG_DEFAULTS[4];
         4'd5:    reg_default = REG_DEFAULTS[5];
         4'd6:    reg_default = REG_DEFAULTS[6];
         4'd7:    reg_default = REG_DEFAULTS[7];
         4'd8:    reg_default = REG_DEFAULTS[8];
         4'd9:    reg_default = REG_DEFAULTS[9];
         default: reg_default = 8'd0;
      endcase
   endfunction

   // One ramp step toward target. The 9-bit sum/difference exposes the carry
   // and borrow so the result clamps at target instead of wrapping.
   function automatic logic [7:0] fader_step(input logic [7:0] cur,
                                             input logic [7:0] target,
                                             input logic [7:0] rate);
      logic [8:0] sum;
      logic [8:0] diff;
      sum  = {1'b0, cur} + {1'b0, rate};
      diff = {1'b0, cur} - {1'b0, rate};
      if (target > cur) begin
         fader_step = (sum >= {1'b0, target}) ? target : sum[7:0];
      end else begin
         fader_step = (diff[8] || (diff[7:0] <= target)) ? target : diff[7:0];
      end
   endfunction

endpackage

// File: rtl/fader_tick_gen.sv
// rtl/fader_tick_gen.sv - loadable down-counter with zero flag for fade tick timing
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (count clears to 0)
//   load_i         load load_val_i into the counter (wins over dec_i)
//   load_val_i     reload value
//   dec_i          decrement by one; holds at zero
//   zero_o         counter currently equals zero
module fader_tick_gen #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/audio_mixer_fader.sv
// rtl/audio_mixer_fader.sv - timed volume/tone ramp initiator on the mixer control bus
//
// Accepts one fade command (address, target, step rate) and walks the mixer
// register from its current value to the target, one write per TICK_DIV
// clocks. Build option FADER_READBACK_EN: when defined the start value is
// read back from the mixer over c_addr/c_dout; when undefined it comes from
// an internal shadow copy of the mixer registers and c_dout is ignored.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_addr/target/rate        register, final value, step per tick (0 = one write)
//   cmd_abort                   cancel the fade in progress (no done pulse)
//   busy, done                  not idle; one-cycle normal-completion pulse
//   c_addr/c_wr/c_din/c_dout    mixer register port
module audio_mixer_fader
   import audio_mixer_pkg::*;
#(
   parameter int NUM_REGS = 10,
   parameter int TICK_DIV = 256,
   parameter int INV_ADDR = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_addr,
   input  logic [7:0] cmd_target,
   input  logic [7:0] cmd_rate,
   input  logic       cmd_abort,
   output logic       busy,
   output logic       done,
   output logic [3:0] c_addr,
   output logic       c_wr,
   output logic [7:0] c_din,
   input  logic [7:0] c_dout
);

   localparam int         CW         = $clog2(TICK_DIV);
   localparam logic [4:0] NUM_REGS_L = 5'(NUM_REGS);
   localparam logic [3:0] INV_ADDR_L = 4'(INV_ADDR);
   // The first tick also spends a cycle in the deciding state, later ticks
   // spend one in STEP, hence the two reload values.
   localparam logic [CW-1:0] LOAD_FIRST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] LOAD_NEXT  = CW'(TICK_DIV - 2);

   fader_state_t state_q, state_d;
   logic [3:0]   addr_q, addr_d;
   logic [7:0]   target_q, target_d;
   logic [7:0]   rate_q, rate_d;
   logic [7:0]   cur_q, cur_d;
   logic [7:0]   next_q, next_d;
   logic [3:0]   c_addr_q, c_addr_d;

   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_dec;
   logic          cnt_zero;

   // Start-of-fade decision inputs; where they come from depends on the build.
   logic [3:0]   dec_addr;
   logic [7:0]   dec_target;
   logic [7:0]   dec_rate;
   logic [7:0]   start_cur;
   logic         addr_ok;
   fader_state_t dec_state;

`ifdef FADER_READBACK_EN
   assign dec_addr   = addr_q;
   assign dec_target = target_q;
   assign dec_rate   = rate_q;
   assign start_cur  = c_dout;
   assign addr_ok    = ({1'b0, dec_addr} < NUM_REGS_L);
`else
   logic [7:0] shadow_q [NUM_REGS];
   logic       unused_dout;

   assign unused_dout = ^c_dout;
   assign dec_addr    = cmd_addr;
   assign dec_target  = cmd_target;
   assign dec_rate    = cmd_rate;
   assign addr_ok     = ({1'b0, dec_addr} < NUM_REGS_L);
   assign start_cur   = addr_ok ? shadow_q[dec_addr] : 8'd0;

   // Tracks what the mixer holds; every bus write goes through STEP.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            shadow_q[i] <= reg_default(4'(i));
         end
      end else if (state_q == ST_STEP) begin
         shadow_q[addr_q] <= next_q;
      end
   end
`endif

   always_comb begin
      dec_state = ST_WAIT;
      if (!addr_ok || (start_cur == dec_target)) begin
         dec_state = ST_DONE;
      end else if ((dec_rate == 8'd0) || (dec_addr == INV_ADDR_L)) begin
         dec_state = ST_STEP;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      target_d = target_q;
      rate_d   = rate_q;
      cur_d    = cur_q;
      next_d   = next_q;
      c_addr_d = c_addr_q;
      cnt_load = 1'b0;
      cnt_val  = LOAD_FIRST;
      cnt_dec  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d   = cmd_addr;
               target_d = cmd_target;
               rate_d   = cmd_rate;
               c_addr_d = cmd_addr;
`ifdef FADER_READBACK_EN
               state_d  = ST_RD_WAIT;
`else
               cur_d    = start_cur;
               state_d  = dec_state;
               if (dec_state == ST_STEP) begin
                  next_d = dec_target;
               end
               cnt_load = (dec_state == ST_WAIT);
`endif
            end
         end
`ifdef FADER_READBACK_EN
         ST_RD_WAIT: begin
            state_d = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            cur_d   = start_cur;
            state_d = dec_state;
            if (dec_state == ST_STEP) begin
               next_d = dec_target;
            end
            cnt_load = (dec_state == ST_WAIT);
         end
`endif
         ST_WAIT: begin
            if (cnt_zero) begin
               next_d  = fader_step(cur_q, target_q, rate_q);
               state_d = ST_STEP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_STEP: begin
            cur_d = next_q;
            if (next_q == target_q) begin
               state_d = ST_DONE;
            end else begin
               state_d  = ST_WAIT;
               cnt_load = 1'b1;
               cnt_val  = LOAD_NEXT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort beats any transition, including a STEP due at this edge;
      // keeping next_q leaves c_din at the last value actually written.
      if ((state_q != ST_IDLE) && cmd_abort) begin
         state_d  = ST_IDLE;
         next_d   = next_q;
         cnt_load = 1'b0;
         cnt_dec  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= 4'd0;
         target_q <= 8'd0;
         rate_q   <= 8'd0;
         cur_q    <= 8'd0;
         next_q   <= 8'd0;
         c_addr_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         target_q <= target_d;
         rate_q   <= rate_d;
         cur_q    <= cur_d;
         next_q   <= next_d;
         c_addr_q <= c_addr_d;
      end
   end

   fader_tick_gen #(
      .W (CW)
   ) u_tick (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   assign cmd_ready = (state_q == ST_IDLE) && !cmd_abort && !rst;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign c_wr      = (state_q == ST_STEP);
   assign c_din     = next_q;
   assign c_addr    = c_addr_q;

endmodule

// File: doc/audio_mixer_fader.md
# audio_mixer_fader

Register-port initiator that drives the audio filter/mixer control bus (`c_addr`/`c_wr`/`c_din`/`c_dout`) to perform timed parameter ramps on volume, bass and treble registers. It accepts one fade command at a time over a valid/ready handshake. It reads the register's current value from the mixer, then writes intermediate values at a fixed tick rate until the target is reached. It sits between the system CPU register file and the mixer, replacing direct CPU writes for click-free volume and tone changes.

## Interface
- `NUM_REGS`, default 10: number of mixer control registers; addresses ≥ `NUM_REGS` are invalid.
- `TICK_DIV`, default 256: clk cycles between successive fade writes; must be ≥2.
- `INV_ADDR`, default 7: address of the invert bitfield register; this register is never ramped.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `cmd_valid`, input, 1: fade command present.
- `cmd_ready`, output, 1: command accepted when `cmd_valid && cmd_ready` at a clk edge.
- `cmd_addr`, input, 4: target register address.
- `cmd_target`, input, 8: final register value.
- `cmd_rate`, input, 8: step size per tick; 0 = immediate single write.
- `cmd_abort`, input, 1: cancel the fade in progress.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse on normal completion.
- `c_addr`, output, 4: mixer register address.
- `c_wr`, output, 1: mixer write strobe, one cycle per write.
- `c_din`, output, 8: mixer write data.
- `c_dout`, input, 8: mixer read data; valid one clk after `c_addr` changes.

## Operation
- States: IDLE, RD_WAIT, RD_CAP, WAIT, STEP, DONE.
- `cmd_ready = (state==IDLE) && !cmd_abort && !rst`.
- **IDLE**, on accept:
  - latch `addr`, `target`, `rate`;
  - drive `c_addr <= cmd_addr`;
  - go to RD_WAIT.
- **RD_WAIT**: wait one cycle for the mixer's registered read; go to RD_CAP.
- **RD_CAP**: `cur <= c_dout`. Then:
  - `addr ≥ NUM_REGS`, or `cur == target`: go to DONE with no write.
  - `rate == 0` or `addr == INV_ADDR`: go to STEP immediately, `next = target`.
  - otherwise: go to WAIT with the tick counter loaded with `TICK_DIV-1`.
- **WAIT**: decrement the counter; at 0, go to STEP.
- **STEP**: `c_wr=1`, `c_din=next`, `cur <= next`. Then:
  - `next == target`: go to DONE.
  - otherwise: go to WAIT, counter loaded with `TICK_DIV-2`.
- **DONE**: `done=1` for one cycle, then IDLE.
- Step arithmetic uses 9-bit unsigned with saturation at the target; no wrap at 0 or 255.
  - Fading up: `next = min(cur+rate, target)`.
  - Fading down: `next = max(cur-rate, target)`.
- Abort:
  - `cmd_abort` sampled high in any busy state forces IDLE at that edge.
  - It takes priority over a STEP due at the same edge, so no write occurs.
  - No `done` pulse is generated.
  - `cmd_abort` in IDLE has no effect except holding `cmd_ready` low.
- `c_addr` holds the last used address in IDLE.
- `c_din` holds its last value; it is meaningful only while `c_wr` is high.

## Timing
- Reset values: state IDLE, `c_addr=0`, `c_wr=0`, `c_din=0`, `busy=0`, `done=0`, counter 0. `cmd_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-fade: `c_wr` is low in the cycle following the reset edge; no partial write.
- Let E0 be the accept edge.
  - `c_dout` is captured at edge E2.
  - The first ramped write cycle starts at edge E2+`TICK_DIV`.
  - Later writes are spaced exactly `TICK_DIV` cycles apart.
  - `done` is asserted in the cycle after the final `c_wr`.
- Immediate write (`rate==0` or `INV_ADDR`): `c_wr` is high in the cycle after E2 and `done` the cycle after that.
- Earliest next accept: the cycle after DONE.

## Configuration
- `FADER_READBACK_EN` defined:
  - the start value is read from the mixer as described above.
- `FADER_READBACK_EN` undefined:
  - RD_WAIT and RD_CAP are removed; `c_dout` is ignored.
  - The start value comes from an internal shadow array of `NUM_REGS`×8.
  - On `rst`, the shadow array loads the package reset-default array; it is updated on every STEP write.
  - All latencies shrink by 2 cycles: the first ramped write starts at E0+`TICK_DIV`.

## Structure
- Package `audio_mixer_pkg`:
  - register address constants (`REG_VOL_A`..`REG_VOL_F`=0..5, `REG_MVOL`=6, `REG_INV`=7, `REG_BASS`=8, `REG_TREB`=9);
  - reset-default array {64,64,64,64,64,64,128,0,25,128};
  - fader state enum.
- Sub-module `fader_tick_gen`: loadable down-counter with a zero flag, used for WAIT timing.

## Test plan
- Readback fade up, `TICK_DIV`=4:
  - Stimulus: mixer reg0=64; cmd addr0, target 68, rate 2.
  - Required: writes 66 then 68, 4 cycles apart; first write at E6; `done` one cycle after the write of 68.
- Saturating fade down:
  - Stimulus: reg6=128; cmd target 0, rate 50.
  - Required: writes 78, 28, 0; no wrap; exactly 3 `c_wr` pulses.
- Immediate writes:
  - Stimulus: addr 9, target 200, rate 0; then addr 7, target 0x05, rate 3.
  - Required: each produces one `c_wr` in the cycle after capture with the target value.
- No-op and invalid commands:
  - Stimulus: target equal to current value; addr 12.
  - Required: `done` pulse, zero `c_wr`, `busy` for 3 cycles.
- Abort:
  - Stimulus: assert `cmd_abort` one cycle after the first write of a 64→128, rate 8 fade.
  - Required: no further `c_wr`, no `done`, `cmd_ready` high the next cycle.
  - Repeat with abort coincident with a due STEP edge: required, that write is suppressed.
- Reset mid-fade:
  - Stimulus: `rst` pulse during WAIT.
  - Required: all outputs at reset values the next cycle; a new command then completes normally.
  - Run in both `FADER_READBACK_EN` builds.
